// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V main control unit:
// FSM state encodings, opcode constants, datapath select encodings and
// small decode helpers used by multicycle_controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Major opcodes handled by the sequencer
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Register write-back source select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MEM    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // True for opcodes that continue past DECODE into EXEC
  function automatic logic is_known_op(input logic [6:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: known = 1'b1;
      default:                                                  known = 1'b0;
    endcase
    return known;
  endfunction

  // Conditional branch resolution from funct3 and the ALU zero flag
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    logic taken;
    case (f3)
      F3_BEQ:  taken = z;
      F3_BNE:  taken = ~z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter for the multi-cycle controller. Counts cycles
// spent waiting on mem_ready and flags a timeout once the count reaches
// MEM_TIMEOUT with the memory still not ready. A ready in the timeout
// cycle suppresses the timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Timeout when the wait count hits the limit and memory is still busy
  always_comb begin
    timeout = 1'b0;
    if (active && !ready && (cnt_q == LIMIT)) begin
      timeout = 1'b1;
    end else begin
      timeout = 1'b0;
    end
  end

  // Next count: restart on clear, advance while waiting, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (active && !ready) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V main control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables combinationally from
// the current state and IR fields, supervises memory accesses with a
// timeout, and counts retired instructions.
// Optional build macro MULTICYCLE_CTRL_TRAP_EN: unknown opcodes trap into
// a HALT state (left only by rst) instead of retiring as NOPs.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 IorD,
  output logic                 PCSrc,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [1:0]           Mem2Reg,
  output logic                 RegWrite,
  output logic                 mem_timeout,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state
);

  state_t                 state_q, state_d;
  logic                   mem_timeout_q, mem_timeout_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire_s;
  logic                   wait_active_s;
  logic                   wait_clear_s;
  logic                   timeout_s;

  // Wait counter only runs in the states that own a memory request
  always_comb begin
    wait_active_s = 1'b0;
    if (!rst && ((state_q == ST_FETCH) || (state_q == ST_MEM))) begin
      wait_active_s = 1'b1;
    end else begin
      wait_active_s = 1'b0;
    end
  end

  // Restart the wait count on every state change and on a timeout retry
  always_comb begin
    wait_clear_s = 1'b0;
    if ((state_d != state_q) || timeout_s) begin
      wait_clear_s = 1'b1;
    end else begin
      wait_clear_s = 1'b0;
    end
  end

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (wait_active_s),
    .ready   (mem_ready),
    .clear   (wait_clear_s),
    .timeout (timeout_s)
  );

  // Next-state, retire strobe and datapath controls from state and IR fields
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    PCSrc    = 1'b0;
    ALUOp    = ALUOP_ADD;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RS2;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = M2R_ALUOUT;
    RegWrite = 1'b0;
    if (rst) begin
      // All controls stay low so any in-flight request is dropped now
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALUOP_ADD;
          if (timeout_s) begin
            // Drop the read and retry from the same PC
            state_d = ST_FETCH;
          end else if (mem_ready) begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = ST_DECODE;
          end else begin
            MemRead = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          // Precompute branch/jump target into ALUOut
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
          if (is_known_op(opcode)) begin
            state_d = ST_EXEC;
          end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state_d = ST_HALT;
`else
            state_d  = ST_FETCH;
            retire_s = 1'b1;
`endif
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              ALUSrcA = SRCA_RS1;
              ALUSrcB = SRCB_RS2;
              ALUOp   = ALUOP_FUNCT;
              state_d = ST_WB;
            end
            OP_ITYPE: begin
              ALUSrcA = SRCA_RS1;
              ALUSrcB = SRCB_IMM;
              ALUOp   = ALUOP_FUNCT;
              state_d = ST_WB;
            end
            OP_LOAD, OP_STORE: begin
              ALUSrcA = SRCA_RS1;
              ALUSrcB = SRCB_IMM;
              ALUOp   = ALUOP_ADD;
              state_d = ST_MEM;
            end
            OP_BRANCH: begin
              ALUSrcA  = SRCA_RS1;
              ALUSrcB  = SRCB_RS2;
              ALUOp    = ALUOP_CMP;
              PCSrc    = 1'b1;
              PCWrite  = branch_taken(funct3, zero);
              state_d  = ST_FETCH;
              retire_s = 1'b1;
            end
            OP_JAL: begin
              // PC already holds the incremented address used as the link
              PCSrc    = 1'b1;
              PCWrite  = 1'b1;
              RegWrite = 1'b1;
              Mem2Reg  = M2R_PC;
              state_d  = ST_FETCH;
              retire_s = 1'b1;
            end
            default: begin
              state_d  = ST_FETCH;
              retire_s = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          IorD = 1'b1;
          if (timeout_s) begin
            // Abort the access: no write-back and no retire
            state_d = ST_FETCH;
          end else if (opcode == OP_LOAD) begin
            MemRead = 1'b1;
            if (mem_ready) begin
              state_d = ST_WB;
            end else begin
              state_d = ST_MEM;
            end
          end else if (opcode == OP_STORE) begin
            MemWrite = 1'b1;
            if (mem_ready) begin
              state_d  = ST_FETCH;
              retire_s = 1'b1;
            end else begin
              state_d = ST_MEM;
            end
          end else begin
            state_d  = ST_FETCH;
            retire_s = 1'b1;
          end
        end
        ST_WB: begin
          RegWrite = 1'b1;
          if (opcode == OP_LOAD) begin
            Mem2Reg = M2R_MEM;
          end else begin
            Mem2Reg = M2R_ALUOUT;
          end
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end
        ST_HALT: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_FETCH;
`endif
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Sticky timeout flag and retired-instruction count
  always_comb begin
    mem_timeout_d = mem_timeout_q | timeout_s;
    instret_d     = instret_q;
    if (retire_s) begin
      instret_d = instret_q + INSTRET_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // State, flag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      mem_timeout_q <= 1'b0;
      instret_q     <= {INSTRET_W{1'b0}};
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
      instret_q     <= instret_d;
    end
  end

`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic halted_q, halted_d;

  // Halt indication follows entry into the trap state
  always_comb begin
    halted_d = 1'b0;
    if (state_d == ST_HALT) begin
      halted_d = 1'b1;
    end else begin
      halted_d = 1'b0;
    end
  end

  // Halt flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign mem_timeout = mem_timeout_q;
  assign instret     = instret_q;
  assign state       = state_q;

endmodule
